gray_decode_monitor: RTL and testbench

//  Receive-side companion of the gray-coded pointer/counter: accepts a gray-coded value stream, decodes it to binary,
//  and checks that successive samples advance by exactly one code step (mod 2^WIDTH). Sits between a gray counter

---
 rtl/gray_decode_monitor_pkg.sv | 24 ++
 rtl/gray_decode_monitor_if.sv | 25 ++
 rtl/gray_decode_monitor_gray_to_bin.sv | 13 +
 rtl/gray_decode_monitor.sv | 108 ++++++++++
 tb/tb_gray_decode_monitor.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/gray_decode_monitor_pkg.sv
// Shared gray-domain definitions: checker FSM encoding and a width-agnostic gray-to-binary helper.
// Latency: none (types and pure functions only); no backpressure.
package gray_decode_monitor_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam int GRAY_MAX_W = 32;

    // Zero-extended codes decode correctly at any width <= GRAY_MAX_W because the
    // leading zeros contribute nothing to the running XOR.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_decode_monitor_if.sv
// Sample stream into the gray monitor and its decoded/status outputs.
// Latency: wires only; the stream has no backpressure.
interface gray_decode_monitor_if #(
    parameter int WIDTH     = 3,
    parameter int CNT_WIDTH = 8
) ();
    logic [WIDTH-1:0]     gray_in;
    logic                 gray_valid;
    logic                 clear_fault;
    logic [WIDTH-1:0]     bin_out;
    logic                 bin_valid;
    logic                 step_ok;
    logic                 fault;
    logic [CNT_WIDTH-1:0] step_count;

    modport master (
        output gray_in, gray_valid, clear_fault,
        input  bin_out, bin_valid, step_ok, fault, step_count
    );

    modport slave (
        input  gray_in, gray_valid, clear_fault,
        output bin_out, bin_valid, step_ok, fault, step_count
    );
endinterface

// File: rtl/gray_decode_monitor_gray_to_bin.sv
// Combinational gray-to-binary decoder for a WIDTH-bit code.
// Latency: 0 cycles; no backpressure.
module gray_to_bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    import gray_decode_monitor_pkg::*;

    assign bin = WIDTH'(gray2bin(GRAY_MAX_W'(gray)));

endmodule

// File: rtl/gray_decode_monitor.sv
// Decodes a gray sample stream and flags any step other than +1 or repeat.
// Latency: 1 cycle from sample to registered outputs; no backpressure, one sample per cycle.
module gray_decode_monitor #(
    parameter int WIDTH     = 3,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    gray_decode_monitor_if.slave mon
);
    import gray_decode_monitor_pkg::*;

    localparam logic [WIDTH-1:0]     BIN_ONE = WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [WIDTH-1:0]     decoded;
    logic [WIDTH-1:0]     exp_next;
    logic                 is_step;
    logic                 is_repeat;
    state_t               state;
    state_t               state_nxt;
    state_t               eff_state;

    logic [WIDTH-1:0]     bin_q,   bin_nxt;
    logic                 vld_q,   vld_nxt;
    logic                 ok_q,    ok_nxt;
    logic                 fault_q, fault_nxt;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_nxt;

    gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
        .gray (mon.gray_in),
        .bin  (decoded)
    );

    // bin_q doubles as the reference sample; carry is dropped so all-ones wraps to zero.
    assign exp_next  = bin_q + BIN_ONE;
    assign is_step   = (decoded == exp_next);
    assign is_repeat = (decoded == bin_q);
    // A clear takes effect before any sample arriving in the same cycle.
    assign eff_state = mon.clear_fault ? S_EMPTY : state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = eff_state;
        if (mon.gray_valid) begin
            case (eff_state)
                S_EMPTY: state_nxt = S_TRACK;
                S_TRACK: state_nxt = (is_step || is_repeat) ? S_TRACK : S_FAULT;
                S_FAULT: state_nxt = S_FAULT;
                default: state_nxt = S_TRACK;
            endcase
        end else if (eff_state != S_TRACK && eff_state != S_FAULT) begin
            state_nxt = S_EMPTY;
        end
    end

    always_comb begin
        bin_nxt   = bin_q;
        vld_nxt   = 1'b0;
        ok_nxt    = 1'b0;
        fault_nxt = mon.clear_fault ? 1'b0 : fault_q;
        cnt_nxt   = mon.clear_fault ? '0 : cnt_q;
        if (mon.gray_valid) begin
            bin_nxt = decoded;
            vld_nxt = 1'b1;
            if (eff_state == S_TRACK) begin
                if (is_step) begin
                    ok_nxt = 1'b1;
                    if (cnt_nxt != '1) begin
                        cnt_nxt = cnt_nxt + CNT_ONE;
                    end
                end else if (!is_repeat) begin
                    fault_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q   <= '0;
            vld_q   <= 1'b0;
            ok_q    <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            bin_q   <= bin_nxt;
            vld_q   <= vld_nxt;
            ok_q    <= ok_nxt;
            fault_q <= fault_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign mon.bin_out    = bin_q;
    assign mon.bin_valid  = vld_q;
    assign mon.step_ok    = ok_q;
    assign mon.fault      = fault_q;
    assign mon.step_count = cnt_q;

endmodule

// File: tb/tb_gray_decode_monitor.sv
// Directed bench for gray_decode_monitor: an 8-bit-counter instance and a 2-bit-counter
// instance for saturation, both WIDTH=3.
module tb_gray_decode_monitor;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    gray_decode_monitor_if #(.WIDTH(3), .CNT_WIDTH(8)) m8 ();
    gray_decode_monitor_if #(.WIDTH(3), .CNT_WIDTH(2)) m2 ();

    gray_decode_monitor #(.WIDTH(3), .CNT_WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .mon   (m8)
    );

    gray_decode_monitor #(.WIDTH(3), .CNT_WIDTH(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .mon   (m2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are read 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m8.gray_in = 3'b000; m8.gray_valid = 1'b0; m8.clear_fault = 1'b0;
        m2.gray_in = 3'b000; m2.gray_valid = 1'b0; m2.clear_fault = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Feed one sample to the 8-bit instance and check every output after the edge.
    task automatic feed8(input string name, input logic [2:0] g, input logic clr,
                         input logic [2:0] e_bin, input logic e_ok, input logic e_fault,
                         input logic [7:0] e_cnt);
        m8.gray_in = g; m8.gray_valid = 1'b1; m8.clear_fault = clr;
        tick();
        m8.gray_valid = 1'b0; m8.clear_fault = 1'b0;
        checks++;
        if ({m8.bin_out, m8.bin_valid, m8.step_ok, m8.fault, m8.step_count} !==
            {e_bin, 1'b1, e_ok, e_fault, e_cnt}) begin
            failures++;
            $display("FAIL %s: bin=%0d vld=%0b ok=%0b fault=%0b cnt=%0d, expected bin=%0d vld=1 ok=%0b fault=%0b cnt=%0d",
                     name, m8.bin_out, m8.bin_valid, m8.step_ok, m8.fault, m8.step_count,
                     e_bin, e_ok, e_fault, e_cnt);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({m8.bin_out, m8.bin_valid, m8.step_ok, m8.fault, m8.step_count} !== 14'd0) begin
            failures++;
            $display("FAIL reset_state8: bin=%0d vld=%0b ok=%0b fault=%0b cnt=%0d, expected all 0",
                     m8.bin_out, m8.bin_valid, m8.step_ok, m8.fault, m8.step_count);
        end
        checks++;
        if ({m2.bin_out, m2.bin_valid, m2.step_ok, m2.fault, m2.step_count} !== 8'd0) begin
            failures++;
            $display("FAIL reset_state2: bin=%0d vld=%0b ok=%0b fault=%0b cnt=%0d, expected all 0",
                     m2.bin_out, m2.bin_valid, m2.step_ok, m2.fault, m2.step_count);
        end
    endtask

    task automatic test_full_sequence();
        logic [2:0] g_tab [9];
        logic [2:0] b_tab [9];
        g_tab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        b_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            feed8($sformatf("seq_%0d", i), g_tab[i], 1'b0, b_tab[i], (i != 0), 1'b0, 8'(i));
        end
        tick();
        checks++;
        if ({m8.bin_out, m8.bin_valid, m8.step_ok, m8.fault, m8.step_count} !==
            {3'd0, 1'b0, 1'b0, 1'b0, 8'd8}) begin
            failures++;
            $display("FAIL seq_idle_hold: bin=%0d vld=%0b ok=%0b fault=%0b cnt=%0d, expected bin=0 vld=0 ok=0 fault=0 cnt=8",
                     m8.bin_out, m8.bin_valid, m8.step_ok, m8.fault, m8.step_count);
        end
    endtask

    task automatic test_illegal_step();
        do_reset();
        feed8("illegal_first", 3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0);
        feed8("illegal_track", 3'b001, 1'b0, 3'd1, 1'b1, 1'b0, 8'd1);
        feed8("illegal_jump",  3'b010, 1'b0, 3'd3, 1'b0, 1'b1, 8'd1);
        feed8("fault_update",  3'b110, 1'b0, 3'd4, 1'b0, 1'b1, 8'd1);
        tick();
        checks++;
        if (m8.fault !== 1'b1 || m8.bin_out !== 3'd4 || m8.bin_valid !== 1'b0) begin
            failures++;
            $display("FAIL fault_sticky: fault=%0b bin=%0d vld=%0b, expected fault=1 bin=4 vld=0",
                     m8.fault, m8.bin_out, m8.bin_valid);
        end
    endtask

    // Runs straight after test_illegal_step, so the monitor is sitting in the fault state.
    task automatic test_clear_with_sample();
        feed8("clear_and_sample", 3'b111, 1'b1, 3'd5, 1'b0, 1'b0, 8'd0);
        feed8("after_clear_step", 3'b101, 1'b0, 3'd6, 1'b1, 1'b0, 8'd1);
    endtask

    task automatic test_repeat();
        do_reset();
        feed8("repeat_first",  3'b011, 1'b0, 3'd2, 1'b0, 1'b0, 8'd0);
        feed8("repeat_same",   3'b011, 1'b0, 3'd2, 1'b0, 1'b0, 8'd0);
        feed8("repeat_then_step", 3'b010, 1'b0, 3'd3, 1'b1, 1'b0, 8'd1);
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        feed8("mid_a", 3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0);
        feed8("mid_b", 3'b001, 1'b0, 3'd1, 1'b1, 1'b0, 8'd1);
        feed8("mid_c", 3'b011, 1'b0, 3'd2, 1'b1, 1'b0, 8'd2);
        m8.gray_in = 3'b010; m8.gray_valid = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m8.gray_valid = 1'b0;
        checks++;
        if ({m8.bin_out, m8.bin_valid, m8.step_ok, m8.fault, m8.step_count} !== 14'd0) begin
            failures++;
            $display("FAIL reset_mid: bin=%0d vld=%0b ok=%0b fault=%0b cnt=%0d, expected all 0",
                     m8.bin_out, m8.bin_valid, m8.step_ok, m8.fault, m8.step_count);
        end
        feed8("post_reset_first", 3'b010, 1'b0, 3'd3, 1'b0, 1'b0, 8'd0);
        feed8("post_reset_step",  3'b110, 1'b0, 3'd4, 1'b1, 1'b0, 8'd1);
    endtask

    task automatic test_saturate();
        logic [2:0] g_tab [7];
        logic [1:0] c_tab [7];
        g_tab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101};
        c_tab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            m2.gray_in = g_tab[i]; m2.gray_valid = 1'b1;
            tick();
            m2.gray_valid = 1'b0;
            checks++;
            if (m2.step_ok !== (i != 0) || m2.step_count !== c_tab[i] || m2.bin_out !== 3'(i)) begin
                failures++;
                $display("FAIL sat_%0d: ok=%0b cnt=%0d bin=%0d, expected ok=%0b cnt=%0d bin=%0d",
                         i, m2.step_ok, m2.step_count, m2.bin_out, (i != 0), c_tab[i], i);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_full_sequence();
        test_illegal_step();
        test_clear_with_sample();
        test_repeat();
        test_reset_mid_stream();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
